// File: rtl/wave_pkg.sv
// Shared definitions for the wave-distortion frame-buffer path:
// frame geometry, address width derivation, writer FSM states and write record.
package wave_pkg;

   // Active frame geometry shared with the wave-distortion filter
   localparam int unsigned WAVE_WIDTH  = 240;
   localparam int unsigned WAVE_HEIGHT = 320;
   localparam int unsigned PIX_W       = 7;

   // Smallest address width that covers every pixel of a w x h frame
   function automatic int unsigned fb_addr_w(input int unsigned w, input int unsigned h);
      int unsigned cells;
      cells = w * h;
      return (cells <= 1) ? 1 : $clog2(cells);
   endfunction

   localparam int unsigned FB_ADDR_W = fb_addr_w(WAVE_WIDTH, WAVE_HEIGHT);

   // Per-frame writer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2
   } fb_state_t;

   // One queued frame-buffer write
   typedef struct packed {
      logic [FB_ADDR_W-1:0] addr;
      logic [PIX_W-1:0]     data;
   } fb_wr_t;

endpackage

// File: rtl/pix_fifo.sv
// First-word-fall-through FIFO. The head entry is visible on rd_data whenever
// empty is low. A write into a full FIFO is accepted when a read happens in the
// same cycle (the freed slot is the one being written).
module pix_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter type         T     = logic [7:0]
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  T                         wr_data,
   input  logic                     rd_en,
   output T                         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   T               mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]  count_q;
   logic           do_rd, do_wr;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || do_rd);

   // Storage array; no reset needed since contents are only observed when not empty
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (do_rd) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({do_wr, do_rd})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/wave_fb_writer.sv
// Scatter-write stage behind the wave-distortion filter. Bounds-checks each
// remapped pixel, converts it to a linear frame-buffer address, queues it and
// drains the queue into one BRAM write port with a valid/ready handshake.
module wave_fb_writer
   import wave_pkg::*;
#(
   parameter int unsigned WIDTH      = WAVE_WIDTH,
   parameter int unsigned HEIGHT     = WAVE_HEIGHT,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned ADDR_W     = FB_ADDR_W
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              data_valid_in,
   input  logic [10:0]       hcount_in,
   input  logic [9:0]        vcount_in,
   input  logic [6:0]        pixel_in,
   input  logic              frame_start_in,
   input  logic              frame_end_in,
   input  logic              mem_ready_in,
   output logic              mem_we_out,
   output logic [ADDR_W-1:0] mem_addr_out,
   output logic [6:0]        mem_data_out,
   output logic [15:0]       drop_count_out,
   output logic              frame_done_out,
   output logic              busy_out
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   fb_state_t     state_q, state_d;
   logic          sa_valid_q, sa_valid_d;
   fb_wr_t        sa_q, sa_d;
   logic [15:0]   drop_q, drop_d;
   logic          done_q, done_d;

   fb_wr_t        fifo_head;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;

   logic          in_range;
   logic          pop;
   logic          drop;
   logic          start_acc;
   logic          fifo_drained;

   assign in_range  = (32'(hcount_in) < WIDTH) && (32'(vcount_in) < HEIGHT);
   assign pop       = !fifo_empty && mem_ready_in;
   assign drop      = sa_valid_q && fifo_full && !pop;
   assign start_acc = (state_q == IDLE) && frame_start_in;

   // True when the FIFO is empty after this cycle's pop (Stage A checked separately)
   assign fifo_drained = fifo_empty || ((fifo_count == CW'(1)) && pop);

   // Stage A: capture an in-range pixel during FILL and form its linear address
   always_comb begin
      sa_valid_d = (state_q == FILL) && data_valid_in && in_range;
      sa_d       = sa_q;
      if (sa_valid_d) begin
         sa_d.addr = FB_ADDR_W'(ADDR_W'(32'(vcount_in) * WIDTH + 32'(hcount_in)));
         sa_d.data = pixel_in;
      end
   end

   // Frame bracketing; DRAIN exits in the cycle of the last pop so done and
   // busy-low appear together in the following cycle
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (frame_start_in) begin
               state_d = FILL;
            end
         end
         FILL: begin
            if (frame_end_in) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!sa_valid_q && fifo_drained) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Overflow drop counter: cleared by an accepted frame start, saturating otherwise
   always_comb begin
      drop_d = drop_q;
      if (start_acc) begin
         drop_d = drop ? 16'd1 : 16'd0;
      end else if (drop && (drop_q != '1)) begin
         drop_d = drop_q + 16'd1;
      end
   end

   // State, Stage A, drop counter and done pulse registers
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= IDLE;
         sa_valid_q <= 1'b0;
         sa_q       <= '0;
         drop_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sa_valid_q <= sa_valid_d;
         sa_q       <= sa_d;
         drop_q     <= drop_d;
         done_q     <= done_d;
      end
   end

   pix_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (fb_wr_t)
   ) u_fifo (
      .clk     (clk_in),
      .rst     (rst_in),
      .wr_en   (sa_valid_q),
      .wr_data (sa_q),
      .rd_en   (mem_ready_in),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign mem_we_out     = !fifo_empty;
   assign mem_addr_out   = mem_we_out ? ADDR_W'(fifo_head.addr) : '0;
   assign mem_data_out   = mem_we_out ? fifo_head.data : '0;
   assign drop_count_out = drop_q;
   assign frame_done_out = done_q;
   assign busy_out       = (state_q != IDLE);

endmodule

// File: tb/tb_wave_fb_writer.sv
// Bench for wave_fb_writer: directed frame scenarios plus a randomized frame,
// compared each cycle against a transaction-level queue model.
module tb_wave_fb_writer;

   localparam int unsigned W     = 240;
   localparam int unsigned H     = 320;
   localparam int unsigned DEPTH = 8;

   logic        clk_in = 1'b0;
   logic        rst_in, data_valid_in, frame_start_in, frame_end_in, mem_ready_in;
   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic [6:0]  pixel_in;
   logic        mem_we_out;
   logic [16:0] mem_addr_out;
   logic [6:0]  mem_data_out;
   logic [15:0] drop_count_out;
   logic        frame_done_out, busy_out;

   always #5 clk_in = ~clk_in;

   wave_fb_writer #(
      .WIDTH      (W),
      .HEIGHT     (H),
      .FIFO_DEPTH (DEPTH),
      .ADDR_W     (17)
   ) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .data_valid_in  (data_valid_in),
      .hcount_in      (hcount_in),
      .vcount_in      (vcount_in),
      .pixel_in       (pixel_in),
      .frame_start_in (frame_start_in),
      .frame_end_in   (frame_end_in),
      .mem_ready_in   (mem_ready_in),
      .mem_we_out     (mem_we_out),
      .mem_addr_out   (mem_addr_out),
      .mem_data_out   (mem_data_out),
      .drop_count_out (drop_count_out),
      .frame_done_out (frame_done_out),
      .busy_out       (busy_out)
   );

   typedef struct packed {
      logic [16:0] a;
      logic [6:0]  d;
   } wr_t;

   // Reference model: queue of pending writes, one staged pixel, frame phase
   wr_t mq[$];
   int  m_phase;   // 0 idle, 1 filling, 2 draining
   bit  m_sv;
   wr_t m_s;
   int  m_drops;
   bit  m_done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int pops = 0;
   int dones = 0;
   int last_pop_cyc = -10;
   int done_cyc = -20;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      bit  pop, drop, nsv;
      wr_t ns;
      if (rst_in) begin
         mq.delete();
         m_phase = 0;
         m_sv    = 0;
         m_drops = 0;
         m_done  = 0;
         return;
      end
      pop  = (mq.size() > 0) && mem_ready_in;
      drop = m_sv && (mq.size() == int'(DEPTH)) && !pop;
      if (pop) void'(mq.pop_front());
      if (m_sv && !drop) mq.push_back(m_s);
      if (m_phase == 0 && frame_start_in) m_drops = drop ? 1 : 0;
      else if (drop && m_drops < 65535) m_drops++;
      nsv  = (m_phase == 1) && data_valid_in && (int'(hcount_in) < int'(W)) && (int'(vcount_in) < int'(H));
      ns.a = 17'(int'(vcount_in) * int'(W) + int'(hcount_in));
      ns.d = pixel_in;
      m_done = 0;
      case (m_phase)
         0: if (frame_start_in) m_phase = 1;
         1: if (frame_end_in) m_phase = 2;
         default: if (!m_sv && mq.size() == 0) begin m_done = 1; m_phase = 0; end
      endcase
      m_sv = nsv;
      if (nsv) m_s = ns;
   endtask

   task automatic check_all();
      chk("we", 32'(mem_we_out), (mq.size() > 0) ? 32'd1 : 32'd0);
      if (mq.size() > 0) begin
         chk("addr", 32'(mem_addr_out), 32'(mq[0].a));
         chk("data", 32'(mem_data_out), 32'(mq[0].d));
      end
      chk("drop", 32'(drop_count_out), 32'(m_drops));
      chk("busy", 32'(busy_out), (m_phase != 0) ? 32'd1 : 32'd0);
      chk("done", 32'(frame_done_out), 32'(m_done));
   endtask

   task automatic tick();
      bit pop_now;
      pop_now = mem_we_out && mem_ready_in;
      model_step();
      @(posedge clk_in);
      cyc++;
      if (pop_now) begin pops++; last_pop_cyc = cyc - 1; end
      #1;
      if (frame_done_out) begin dones++; done_cyc = cyc; end
      check_all();
   endtask

   task automatic pix(input int h, input int v, input int p);
      data_valid_in = 1'b1;
      hcount_in     = 11'(h);
      vcount_in     = 10'(v);
      pixel_in      = 7'(p);
   endtask

   task automatic wait_done(input string tag);
      for (int k = 0; k < 60 && !frame_done_out; k++) tick();
      chk(tag, 32'(frame_done_out), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int pb;
      rst_in = 1'b1; data_valid_in = 0; frame_start_in = 0; frame_end_in = 0;
      mem_ready_in = 0; hcount_in = '0; vcount_in = '0; pixel_in = '0;
      tick(); tick();
      chk("rst_we", 32'(mem_we_out), 0);
      chk("rst_busy", 32'(busy_out), 0);
      chk("rst_drop", 32'(drop_count_out), 0);
      chk("rst_done", 32'(frame_done_out), 0);
      rst_in = 1'b0;
      tick();

      // single pixel latency and address
      mem_ready_in = 1; frame_start_in = 1; tick(); frame_start_in = 0;
      chk("start_busy", 32'(busy_out), 1);
      pix(5, 2, 7'h55); tick(); data_valid_in = 0;
      chk("lat_n1_we", 32'(mem_we_out), 0);
      tick();
      chk("lat_we", 32'(mem_we_out), 1);
      chk("lat_addr", 32'(mem_addr_out), 485);
      chk("lat_data", 32'(mem_data_out), 32'h55);
      tick();
      chk("lat_after_we", 32'(mem_we_out), 0);

      // out-of-range pixels
      pix(240, 0, 1); tick(); pix(0, 320, 2); tick(); pix(2047, 1023, 3); tick();
      data_valid_in = 0;
      repeat (3) begin
         tick();
         chk("oor_we", 32'(mem_we_out), 0);
      end
      chk("oor_drop", 32'(drop_count_out), 0);

      // overflow with the port stalled
      mem_ready_in = 0;
      for (int i = 0; i < 20; i++) begin pix(i, 10, i); tick(); end
      data_valid_in = 0; tick(); tick();
      chk("ovf_drop", 32'(drop_count_out), 12);
      chk("ovf_head", 32'(mem_addr_out), 2400);
      pb = pops; mem_ready_in = 1;
      repeat (12) tick();
      chk("ovf_pops", 32'(pops - pb), 8);

      // frame end with 5 pending, ready toggling
      mem_ready_in = 0;
      for (int i = 0; i < 5; i++) begin pix(100 + i, 300 + i, $urandom_range(0, 127)); tick(); end
      data_valid_in = 0; tick();
      pb = pops; dones = 0; frame_end_in = 1;
      for (int k = 0; k < 40 && dones == 0; k++) begin
         mem_ready_in = (k % 2 == 0);
         tick();
         frame_end_in = 0;
         if (frame_done_out) chk("drain_busy", 32'(busy_out), 0);
      end
      chk("drain_pops", 32'(pops - pb), 5);
      chk("drain_done_cyc", 32'(done_cyc), 32'(last_pop_cyc + 1));
      repeat (3) tick();
      chk("drain_done_once", 32'(dones), 1);

      // pixels while idle are ignored; start clears drops; start in fill ignored
      mem_ready_in = 1;
      repeat (3) begin pix(1, 1, 9); tick(); chk("idle_we", 32'(mem_we_out), 0); end
      data_valid_in = 0;
      frame_start_in = 1; tick(); frame_start_in = 0;
      chk("start_clr_drop", 32'(drop_count_out), 0);
      mem_ready_in = 0;
      for (int i = 0; i < 10; i++) begin pix(239 - i, 319 - i, i + 40); tick(); end
      data_valid_in = 0; tick(); tick();
      chk("fill_drop", 32'(drop_count_out), 2);
      frame_start_in = 1; tick(); frame_start_in = 0;
      chk("fill_start_drop", 32'(drop_count_out), 2);
      chk("fill_start_busy", 32'(busy_out), 1);
      mem_ready_in = 1; repeat (10) tick();
      frame_end_in = 1; tick(); frame_end_in = 0;
      wait_done("fill_done");

      // start and end together, then an empty end
      frame_start_in = 1; frame_end_in = 1; tick(); frame_start_in = 0; frame_end_in = 0;
      repeat (3) begin tick(); chk("se_busy", 32'(busy_out), 1); end
      frame_end_in = 1; tick(); frame_end_in = 0;
      chk("e_done1", 32'(frame_done_out), 0);
      tick();
      chk("e_done2", 32'(frame_done_out), 1);
      chk("e_busy2", 32'(busy_out), 0);
      tick();
      chk("e_done3", 32'(frame_done_out), 0);

      // asynchronous reset in the middle of a drain
      frame_start_in = 1; tick(); frame_start_in = 0;
      mem_ready_in = 0;
      for (int i = 0; i < 3; i++) begin pix(7 + i, 7, i); tick(); end
      data_valid_in = 0; tick();
      frame_end_in = 1; tick(); frame_end_in = 0; tick();
      chk("arst_pre_we", 32'(mem_we_out), 1);
      #2 rst_in = 1'b1;
      #1;
      chk("arst_we", 32'(mem_we_out), 0);
      chk("arst_busy", 32'(busy_out), 0);
      chk("arst_done", 32'(frame_done_out), 0);
      tick();
      rst_in = 1'b0; dones = 0; mem_ready_in = 1;
      repeat (10) tick();
      chk("arst_nodone", 32'(dones), 0);

      // randomized frame
      frame_start_in = 1; tick(); frame_start_in = 0;
      for (int i = 0; i < 400; i++) begin
         data_valid_in = ($urandom_range(0, 3) != 0);
         hcount_in     = 11'($urandom_range(0, 255));
         vcount_in     = 10'($urandom_range(0, 339));
         pixel_in      = 7'($urandom_range(0, 127));
         mem_ready_in  = ($urandom_range(0, 2) != 0);
         tick();
      end
      data_valid_in = 0; mem_ready_in = 1;
      frame_end_in = 1; tick(); frame_end_in = 0;
      wait_done("rand_done");
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
